// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for the RSA256 core: loads N, D and A MSB-first,
// launches the core, then streams the low OUT_BYTES of the result back out.
module rsa_stream_ctrl #(
   parameter int WIDTH     = 256,
   parameter int OUT_BYTES = 31
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [7:0]       i_rx_data,
   input  logic             i_rx_valid,
   output logic             o_rx_ready,
   output logic [7:0]       o_tx_data,
   output logic             o_tx_valid,
   input  logic             i_tx_ready,
   input  logic             i_key_reload,
   output logic             o_core_start,
   output logic [WIDTH-1:0] o_core_a,
   output logic [WIDTH-1:0] o_core_d,
   output logic [WIDTH-1:0] o_core_n,
   input  logic [WIDTH-1:0] i_core_result,
   input  logic             i_core_finished,
   output logic             o_busy
);

   localparam int RX_BYTES = WIDTH / 8;
   localparam int CW       = $clog2(RX_BYTES) + 1;
   localparam int TXW      = 8 * OUT_BYTES;

   localparam logic [2:0] S_GET_N = 3'd0;
   localparam logic [2:0] S_GET_D = 3'd1;
   localparam logic [2:0] S_GET_A = 3'd2;
   localparam logic [2:0] S_START = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_SEND  = 3'd5;

   logic [2:0]       state_reg, state_next;
   logic [CW-1:0]    cnt_reg, cnt_next;
   logic [WIDTH-1:0] n_reg, n_next;
   logic [WIDTH-1:0] d_reg, d_next;
   logic [WIDTH-1:0] a_reg, a_next;
   logic [TXW-1:0]   tx_sr_reg, tx_sr_next;
   logic [WIDTH-1:0] rx_byte_ext;
   logic             rx_last, tx_last;

   // Result bits above the transmitted window are discarded by design.
   if (TXW < WIDTH) begin : g_drop_hi
      logic unused_result_hi;
      assign unused_result_hi = ^i_core_result[WIDTH-1:TXW];
   end

   assign o_rx_ready   = (state_reg == S_GET_N) || (state_reg == S_GET_D) ||
                         (state_reg == S_GET_A);
   assign o_core_start = (state_reg == S_START);
   assign o_tx_valid   = (state_reg == S_SEND);
   assign o_busy       = (state_reg == S_START) || (state_reg == S_WAIT) ||
                         (state_reg == S_SEND);
   assign o_tx_data    = tx_sr_reg[TXW-1 -: 8];
   assign o_core_n     = n_reg;
   assign o_core_d     = d_reg;
   assign o_core_a     = a_reg;

   assign rx_byte_ext = {{(WIDTH-8){1'b0}}, i_rx_data};
   assign rx_last     = (cnt_reg == CW'(RX_BYTES - 1));
   assign tx_last     = (cnt_reg == CW'(OUT_BYTES - 1));

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      n_next     = n_reg;
      d_next     = d_reg;
      a_next     = a_reg;
      tx_sr_next = tx_sr_reg;
      if (i_key_reload) begin
         // Abort wins over everything; operand registers are simply overwritten later.
         state_next = S_GET_N;
         cnt_next   = '0;
      end else begin
         case (state_reg)
            S_GET_N, S_GET_D, S_GET_A: begin
               if (i_rx_valid) begin
                  case (state_reg)
                     S_GET_N: n_next = (n_reg << 8) | rx_byte_ext;
                     S_GET_D: d_next = (d_reg << 8) | rx_byte_ext;
                     default: a_next = (a_reg << 8) | rx_byte_ext;
                  endcase
                  if (rx_last) begin
                     cnt_next = '0;
                     case (state_reg)
                        S_GET_N: state_next = S_GET_D;
                        S_GET_D: state_next = S_GET_A;
                        default: state_next = S_START;
                     endcase
                  end else begin
                     cnt_next = cnt_reg + CW'(1);
                  end
               end
            end
            S_START: state_next = S_WAIT;
            S_WAIT: begin
               if (i_core_finished) begin
                  tx_sr_next = i_core_result[TXW-1:0];
                  state_next = S_SEND;
               end
            end
            S_SEND: begin
               if (i_tx_ready) begin
                  tx_sr_next = tx_sr_reg << 8;
                  if (tx_last) begin
                     cnt_next   = '0;
                     state_next = S_GET_A;  // key stays loaded for the next ciphertext
                  end else begin
                     cnt_next = cnt_reg + CW'(1);
                  end
               end
            end
            default: begin
               state_next = S_GET_N;
               cnt_next   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= S_GET_N;
         cnt_reg   <= '0;
         n_reg     <= '0;
         d_reg     <= '0;
         a_reg     <= '0;
         tx_sr_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         n_reg     <= n_next;
         d_reg     <= d_next;
         a_reg     <= a_next;
         tx_sr_reg <= tx_sr_next;
      end
   end

endmodule

// File: doc/rsa_stream_ctrl.md
Name: rsa_stream_ctrl

Overview:
- Byte-stream front end that acts as initiator for the RSA256 decryption core.
- Deserialises modulus N, private key D and ciphertext blocks A from an 8-bit valid/ready receive stream, then launches the core with a one-cycle start pulse.
- Waits for the core's finished pulse, then serialises the plaintext back out on an 8-bit valid/ready transmit stream.
- Sits between the UART/bus byte interface and the core, and is the far end of the core's start/finished handshake.

Parameters:
- WIDTH, 256, operand width in bits; must be a multiple of 8; RX_BYTES = WIDTH/8.
- OUT_BYTES, 31, bytes transmitted per result, taken from the low end of the result (1..WIDTH/8).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_rx_data  in  8  receive byte
- i_rx_valid  in  1  receive byte valid
- o_rx_ready  out  1  controller accepts receive byte
- o_tx_data  out  8  transmit byte
- o_tx_valid  out  1  transmit byte valid
- i_tx_ready  in  1  sink accepts transmit byte
- i_key_reload  in  1  synchronous abort; return to key loading
- o_core_start  out  1  one-cycle start pulse to core
- o_core_a  out  WIDTH  ciphertext to core
- o_core_d  out  WIDTH  private key to core
- o_core_n  out  WIDTH  modulus to core
- i_core_result  in  WIDTH  core result, valid in the i_core_finished cycle
- i_core_finished  in  1  core one-cycle done pulse
- o_busy  out  1  high in S_START, S_WAIT, S_SEND

Behaviour:
- Reset is asynchronous (i_rst, active-high); clock is i_clk. On reset:
  - state = S_GET_N, byte counter = 0.
  - N, D, A and result registers = 0.
  - o_core_start = 0, o_tx_valid = 0, o_tx_data = 0.
  - o_rx_ready = 1, because it is decoded from state.
- States: S_GET_N, S_GET_D, S_GET_A, S_START, S_WAIT, S_SEND.
- Receive:
  - o_rx_ready = 1 exactly in S_GET_N/D/A.
  - A byte is accepted on a clock edge where i_rx_valid && o_rx_ready.
  - Bytes arrive MSB first. The target register shifts left 8 and i_rx_data enters at [7:0].
  - The counter increments per accepted byte. The RX_BYTES-th byte clears the counter and advances the state: N->D, D->A, A->S_START.
  - No handshake means no change.
- S_START: o_core_start = 1 for exactly one cycle, then S_WAIT. The start pulse appears in the cycle after the last A byte is accepted.
- o_core_a/d/n are driven directly from the registers. They do not change from the start pulse until the result is captured.
- S_WAIT: on i_core_finished, capture i_core_result into the tx shift register and go to S_SEND. i_core_finished in any other state is ignored.
- S_SEND:
  - o_tx_valid = 1.
  - Bytes are sent k = OUT_BYTES-1 down to 0, byte k = result[8k+7:8k]. Result bits above 8*OUT_BYTES are dropped.
  - o_tx_data stays stable while o_tx_valid && !i_tx_ready.
  - On handshake the next byte is presented in the next cycle, so the peak rate is one byte per cycle.
  - After the last handshake, o_tx_valid = 0 and state returns to S_GET_A. N and D are retained, so successive ciphertexts need no key reload.
- First tx byte latency: o_tx_valid rises the cycle after i_core_finished.
- i_key_reload has priority over all other events in the same cycle:
  - Next state = S_GET_N, counter = 0, o_tx_valid = 0, o_core_start = 0.
  - Register contents are not cleared; they are overwritten by the new load.
  - A core run still in flight is abandoned. A late i_core_finished lands in S_GET_* and is ignored.
- Counter width is clog2(RX_BYTES)+1. The counter never exceeds RX_BYTES-1 in receive, or OUT_BYTES-1 in send.
- i_rst mid-operation (any state) returns to the reset values on assertion, without waiting for a clock.

Test Plan:
1. Load N bytes 0x01..0x20, D bytes 0x21..0x40, A bytes 0x41..0x60 with i_rx_valid held high -> o_core_start pulses once, 1 cycle after the 96th byte. At that pulse: o_core_n=0x0102..20, o_core_d=0x2122..40, o_core_a=0x4142..60, o_busy=1, o_rx_ready=0.
2. Core model returns result 0x00 followed by 31 bytes 0xAA,0xAB,...,0xC8, i_tx_ready=1 -> exactly 31 bytes 0xAA..0xC8 in order on consecutive cycles, then o_tx_valid=0 and o_rx_ready=1 (S_GET_A).
3. Same as 2 with i_tx_ready toggled 1,0,0,1,... -> o_tx_data holds each byte while ready=0, no byte is dropped or repeated, 31 bytes total.
4. After 2, send a second A (32 bytes 0xFF) without reload -> start pulse with o_core_n and o_core_d unchanged and o_core_a=all 0xFF.
5. Assert i_key_reload on the 10th tx byte while i_core_finished is pulsed at the same cycle -> o_tx_valid=0 next cycle, state S_GET_N, finished ignored, next 32 rx bytes land in o_core_n.
6. Assert i_rst asynchronously in S_WAIT, then pulse i_core_finished -> all outputs at reset values immediately, o_rx_ready=1, no tx activity.
